// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N byte requesters.
// Holds a per-channel baud divider / stop-bit table and returns ack or timeout error per grant.
module uart_tx_scheduler #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEF_COMP = 434,
  parameter int unsigned TIMEOUT  = 4096,
  localparam int unsigned CW      = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_sched_en,
  input  logic [N-1:0]   i_ch_en,
  input  logic [N-1:0]   i_req_vld,
  input  logic [8*N-1:0] i_req_data,
  output logic [N-1:0]   o_req_ack,
  output logic [N-1:0]   o_req_err,
  input  logic           i_cfg_we,
  input  logic [CW-1:0]  i_cfg_ch,
  input  logic [15:0]    i_cfg_comp,
  input  logic [1:0]     i_cfg_stop,
  output logic           o_tx_req,
  output logic [7:0]     o_tx_data,
  output logic [15:0]    o_comp,
  output logic [1:0]     o_stop_sel,
  output logic           o_tr_en,
  input  logic           i_tx_req_ack,
  output logic           o_busy,
  output logic [CW-1:0]  o_gnt_id
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  localparam logic [15:0]   DefComp  = 16'(DEF_COMP);
  localparam logic [15:0]   TimerMax = 16'(TIMEOUT - 1);
  localparam logic [CW-1:0] LastRst  = CW'(N - 1);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_last, w_last_nxt;
  logic [CW-1:0] r_gnt, w_gnt_nxt;
  logic [15:0]   r_timer, w_timer_nxt;
  logic          r_tx_req, w_tx_req_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic [15:0]   r_comp, w_comp_nxt;
  logic [1:0]    r_stop, w_stop_nxt;
  logic [N-1:0]  r_ack, w_ack_nxt;
  logic [N-1:0]  r_err, w_err_nxt;
  logic          r_tr_en;
  logic [15:0]   r_cfg_comp [N];
  logic [1:0]    r_cfg_stop [N];

  logic [N-1:0]  w_elig;
  logic          w_found;
  logic [CW-1:0] w_sel;

  // Descending scan so the smallest offset from last+1 is the one that sticks.
  function automatic logic [CW:0] rr_pick(input logic [N-1:0] elig, input logic [CW-1:0] last);
    logic [CW:0] pick;
    pick = '0;
    for (int i = int'(N); i >= 1; i--) begin
      logic [CW-1:0] idx;
      idx = CW'((32'(last) + 32'(i)) % N);
      if (elig[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_elig = i_req_vld & i_ch_en & {N{i_sched_en}};
  assign {w_found, w_sel} = rr_pick(w_elig, r_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gnt_nxt     = r_gnt;
    w_timer_nxt   = r_timer;
    w_tx_req_nxt  = r_tx_req;
    w_tx_data_nxt = r_tx_data;
    w_comp_nxt    = r_comp;
    w_stop_nxt    = r_stop;
    w_ack_nxt     = '0;
    w_err_nxt     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt   = StReq;
          w_tx_req_nxt  = 1'b1;
          w_tx_data_nxt = i_req_data[8*w_sel +: 8];
          w_comp_nxt    = r_cfg_comp[w_sel];
          w_stop_nxt    = r_cfg_stop[w_sel];
          w_gnt_nxt     = w_sel;
          w_timer_nxt   = '0;
        end
      end
      StReq: begin
        if (i_tx_req_ack) begin
          w_ack_nxt[r_gnt] = 1'b1;
          w_tx_req_nxt     = 1'b0;
          w_last_nxt       = r_gnt;
          w_timer_nxt      = '0;
          w_state_nxt      = StGap;
        end else if (r_timer == TimerMax) begin
          w_err_nxt[r_gnt] = 1'b1;
          w_tx_req_nxt     = 1'b0;
          w_last_nxt       = r_gnt;
          w_timer_nxt      = '0;
          w_state_nxt      = StGap;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      StGap:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_last    <= LastRst;
      r_gnt     <= '0;
      r_timer   <= '0;
      r_tx_req  <= 1'b0;
      r_tx_data <= '0;
      r_comp    <= DefComp;
      r_stop    <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_tr_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timer   <= w_timer_nxt;
      r_tx_req  <= w_tx_req_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_comp    <= w_comp_nxt;
      r_stop    <= w_stop_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_tr_en   <= i_sched_en;
    end
  end

  // Table is read at grant time, so a same-edge write lands only for the next grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(N); i++) begin
        r_cfg_comp[i] <= DefComp;
        r_cfg_stop[i] <= '0;
      end
    end else if (i_cfg_we && (32'(i_cfg_ch) < N)) begin
      r_cfg_comp[i_cfg_ch] <= i_cfg_comp;
      r_cfg_stop[i_cfg_ch] <= i_cfg_stop;
    end
  end

  assign o_req_ack  = r_ack;
  assign o_req_err  = r_err;
  assign o_tx_req   = r_tx_req;
  assign o_tx_data  = r_tx_data;
  assign o_comp     = r_comp;
  assign o_stop_sel = r_stop;
  assign o_tr_en    = r_tr_en;
  assign o_busy     = (r_state != StIdle);
  assign o_gnt_id   = r_gnt;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: scenario tasks against a round-robin / config-table model.
module tb_uart_tx_scheduler;
  localparam int NCH = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        i_reset, i_sched_en, i_cfg_we, i_tx_req_ack;
  logic [3:0]  i_ch_en, i_req_vld;
  logic [31:0] i_req_data;
  logic [1:0]  i_cfg_ch, i_cfg_stop;
  logic [15:0] i_cfg_comp;
  logic [3:0]  o_req_ack, o_req_err;
  logic        o_tx_req, o_tr_en, o_busy;
  logic [7:0]  o_tx_data;
  logic [15:0] o_comp;
  logic [1:0]  o_stop_sel, o_gnt_id;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_last;
  logic [15:0] m_comp [NCH];
  logic [1:0]  m_stop [NCH];

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N(NCH), .DEF_COMP(434), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_sched_en(i_sched_en), .i_ch_en(i_ch_en),
    .i_req_vld(i_req_vld), .i_req_data(i_req_data), .o_req_ack(o_req_ack),
    .o_req_err(o_req_err), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch), .i_cfg_comp(i_cfg_comp),
    .i_cfg_stop(i_cfg_stop), .o_tx_req(o_tx_req), .o_tx_data(o_tx_data), .o_comp(o_comp),
    .o_stop_sel(o_stop_sel), .o_tr_en(o_tr_en), .i_tx_req_ack(i_tx_req_ack), .o_busy(o_busy),
    .o_gnt_id(o_gnt_id)
  );

  // Next grant: first eligible channel after the last served one, modulo NCH.
  function automatic int rr_pick(input logic [3:0] elig);
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (m_last + i) % NCH;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NCH - 1;
    for (int i = 0; i < NCH; i++) begin
      m_comp[i] = 16'd434;
      m_stop[i] = 2'd0;
    end
  endtask

  task automatic cfg_write(input int ch, input logic [15:0] c, input logic [1:0] s);
    i_cfg_we = 1'b1; i_cfg_ch = 2'(ch); i_cfg_comp = c; i_cfg_stop = s;
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_comp[ch] = c;
    m_stop[ch] = s;
  endtask

  // Plays the transmitter for one frame; ack_at = high-cycle number to ack on (0 = never).
  task automatic do_frame(input int ack_at, input logic [3:0] drop_mask, input logic mid_we,
                          input logic [15:0] mid_comp, input logic [1:0] mid_stop,
                          output int wt, output int high, output int g, output logic [7:0] data,
                          output logic [15:0] comp, output logic [1:0] stop,
                          output logic [3:0] ack, output logic [3:0] err,
                          output logic pulse_one, output logic busy_end);
    wt = 0; high = 0; g = -1; data = '0; comp = '0; stop = '0;
    ack = '0; err = '0; pulse_one = 1'b0; busy_end = 1'b1;
    do begin
      @(negedge clk);
      i_cfg_we = 1'b0;
      wt++;
    end while (o_tx_req !== 1'b1 && wt < 40);
    if (o_tx_req !== 1'b1) return;
    g = int'(o_gnt_id);
    data = o_tx_data;
    while (o_tx_req === 1'b1 && high < 100) begin
      high++;
      comp = o_comp;
      stop = o_stop_sel;
      i_tx_req_ack = (high == ack_at);
      if (mid_we && high == 1) begin
        i_cfg_we = 1'b1; i_cfg_ch = 2'(g); i_cfg_comp = mid_comp; i_cfg_stop = mid_stop;
      end else begin
        i_cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    i_tx_req_ack = 1'b0;
    i_cfg_we = 1'b0;
    ack = o_req_ack;
    err = o_req_err;
    i_req_vld = i_req_vld & ~drop_mask;
    @(negedge clk);
    pulse_one = (o_req_ack === 4'b0) && (o_req_err === 4'b0) && (o_tx_req === 1'b0);
    busy_end = o_busy;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_sched_en = 1'b1; i_ch_en = 4'hF; i_req_vld = '0; i_req_data = '0;
    i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_comp = '0; i_cfg_stop = '0; i_tx_req_ack = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (o_tx_req !== 1'b0) begin n_fail++; $display("FAIL rst_tx_req: got %b want 0", o_tx_req); end
    n_checks++; if (o_comp !== 16'd434) begin n_fail++; $display("FAIL rst_comp: got %0d want 434", o_comp); end
    n_checks++; if (o_stop_sel !== 2'd0) begin n_fail++; $display("FAIL rst_stop: got %0d want 0", o_stop_sel); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_checks++; if (o_gnt_id !== 2'd0) begin n_fail++; $display("FAIL rst_gnt: got %0d want 0", o_gnt_id); end
    n_checks++; if ({o_req_ack, o_req_err} !== 8'h00) begin n_fail++; $display("FAIL rst_ack_err: got %h want 00", {o_req_ack, o_req_err}); end
    n_checks++; if (o_tr_en !== 1'b0) begin n_fail++; $display("FAIL rst_tr_en: got %b want 0", o_tr_en); end
    n_checks++; if (o_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", o_tx_data); end
    i_reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (o_tr_en !== 1'b1) begin n_fail++; $display("FAIL tr_en_follow: got %b want 1", o_tr_en); end
  endtask

  task automatic test_single();
    int wt, h, g; logic [7:0] d; logic [15:0] c; logic [1:0] s; logic [3:0] a, e; logic p, b;
    i_req_data = $urandom;
    i_req_data[7:0] = 8'hA5;
    i_req_vld = 4'b0001;
    do_frame(3, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (wt !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", wt); end
    n_checks++; if (g !== 0) begin n_fail++; $display("FAIL single_gnt: got %0d want 0", g); end
    n_checks++; if (h !== 3) begin n_fail++; $display("FAIL single_high: got %0d want 3", h); end
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", d); end
    n_checks++; if (c !== 16'd434 || s !== 2'd0) begin n_fail++; $display("FAIL single_cfg: got %0d/%0d want 434/0", c, s); end
    n_checks++; if (a !== 4'b0001 || e !== 4'b0) begin n_fail++; $display("FAIL single_ack: got %b/%b want 0001/0000", a, e); end
    n_checks++; if (p !== 1'b1 || b !== 1'b0) begin n_fail++; $display("FAIL single_end: got pulse_one=%b busy=%b want 1/0", p, b); end
    m_last = 0;
  endtask

  task automatic test_round_robin();
    int wt, h, g, exp_g; logic [7:0] d, exp_d; logic [15:0] c; logic [1:0] s;
    logic [3:0] a, e; logic p, b; int ack_at;
    i_req_data = $urandom;
    i_req_vld = 4'hF;
    for (int f = 0; f < 8; f++) begin
      exp_g = rr_pick(i_req_vld & i_ch_en);
      exp_d = i_req_data[8*exp_g +: 8];
      ack_at = int'($urandom_range(1, 6));
      do_frame(ack_at, (f == 7) ? 4'hF : 4'h0, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
      n_checks++; if (g !== exp_g || wt !== 1) begin n_fail++; $display("FAIL rr_gnt[%0d]: got ch%0d after %0d want ch%0d after 1", f, g, wt, exp_g); end
      n_checks++; if (d !== exp_d || h !== ack_at) begin n_fail++; $display("FAIL rr_data[%0d]: got %h/%0d want %h/%0d", f, d, h, exp_d, ack_at); end
      n_checks++; if (a !== 4'(1 << exp_g) || e !== 4'b0 || p !== 1'b1) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b/%b/%b want %b/0000/1", f, a, e, p, 4'(1 << exp_g)); end
      m_last = exp_g;
      i_req_data[8*exp_g +: 8] = 8'($urandom);
    end
  endtask

  task automatic test_cfg();
    int wt, h, g; logic [7:0] d; logic [15:0] c; logic [1:0] s; logic [3:0] a, e; logic p, b;
    cfg_write(2, 16'd5208, 2'd2);
    i_req_vld = 4'b0100;
    do_frame(4, 4'hF, 1'b1, 16'd1302, 2'd1, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (g !== 2 || c !== m_comp[2] || s !== m_stop[2]) begin n_fail++; $display("FAIL cfg_first: got ch%0d %0d/%0d want ch2 %0d/%0d", g, c, s, m_comp[2], m_stop[2]); end
    m_comp[2] = 16'd1302; m_stop[2] = 2'd1; m_last = 2;
    // write and grant on the same edge: grant must still see the previous entry
    i_req_vld = 4'b0100;
    i_cfg_we = 1'b1; i_cfg_ch = 2'd2; i_cfg_comp = 16'd600; i_cfg_stop = 2'd3;
    do_frame(2, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (c !== m_comp[2] || s !== m_stop[2]) begin n_fail++; $display("FAIL cfg_mid_write: got %0d/%0d want %0d/%0d", c, s, m_comp[2], m_stop[2]); end
    m_comp[2] = 16'd600; m_stop[2] = 2'd3;
    i_req_vld = 4'b0100;
    do_frame(1, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (c !== m_comp[2] || s !== m_stop[2]) begin n_fail++; $display("FAIL cfg_same_edge: got %0d/%0d want %0d/%0d", c, s, m_comp[2], m_stop[2]); end
    n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL cfg_ack: got %b want 0100", a); end
  endtask

  task automatic test_timeout();
    int wt, h, g; logic [7:0] d; logic [15:0] c; logic [1:0] s; logic [3:0] a, e; logic p, b;
    i_req_vld = 4'b0010;
    do_frame(0, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (h !== TMO) begin n_fail++; $display("FAIL tmo_high: got %0d want %0d", h, TMO); end
    n_checks++; if (e !== 4'b0010 || a !== 4'b0 || p !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got err=%b ack=%b one=%b want 0010/0000/1", e, a, p); end
    m_last = 1;
    i_req_vld = 4'b0010;
    do_frame(TMO, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (h !== TMO || a !== 4'b0010 || e !== 4'b0) begin n_fail++; $display("FAIL tmo_ack_wins: got high=%0d ack=%b err=%b want %0d/0010/0000", h, a, e, TMO); end
  endtask

  task automatic test_random();
    int wt, h, g, exp_g, ack_at, exp_h; logic [7:0] d, exp_d; logic [15:0] c; logic [1:0] s;
    logic [3:0] a, e, elig; logic p, b; int seen;
    for (int ch = 0; ch < NCH; ch++) cfg_write(ch, 16'($urandom_range(1, 65535)), 2'($urandom));
    for (int it = 0; it < 16; it++) begin
      i_ch_en = 4'($urandom);
      i_req_vld = 4'($urandom_range(1, 15));
      i_req_data = $urandom;
      elig = i_req_vld & i_ch_en;
      if (elig == 4'b0) begin
        seen = 0;
        repeat (4) begin @(negedge clk); if (o_tx_req !== 1'b0 || o_busy !== 1'b0) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rand_nogrant[%0d]: got %0d busy cycles want 0", it, seen); end
        i_req_vld = '0;
        continue;
      end
      exp_g = rr_pick(elig);
      exp_d = i_req_data[8*exp_g +: 8];
      ack_at = int'($urandom_range(0, TMO));
      exp_h = (ack_at == 0) ? TMO : ack_at;
      do_frame(ack_at, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
      n_checks++; if (g !== exp_g || d !== exp_d || h !== exp_h) begin n_fail++; $display("FAIL rand_frame[%0d]: got ch%0d %h %0d want ch%0d %h %0d", it, g, d, h, exp_g, exp_d, exp_h); end
      n_checks++; if (c !== m_comp[exp_g] || s !== m_stop[exp_g]) begin n_fail++; $display("FAIL rand_cfg[%0d]: got %0d/%0d want %0d/%0d", it, c, s, m_comp[exp_g], m_stop[exp_g]); end
      n_checks++; if (a !== ((ack_at != 0) ? 4'(1 << exp_g) : 4'b0) || e !== ((ack_at == 0) ? 4'(1 << exp_g) : 4'b0) || p !== 1'b1) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got ack=%b err=%b one=%b ack_at=%0d ch%0d", it, a, e, p, ack_at, exp_g);
      end
      m_last = exp_g;
    end
  endtask

  task automatic test_block();
    int wt, h, g, seen; logic [7:0] d; logic [15:0] c; logic [1:0] s; logic [3:0] a, e; logic p, b;
    i_ch_en = 4'b1011; i_req_vld = 4'b0100;
    seen = 0;
    repeat (6) begin @(negedge clk); if (o_tx_req !== 1'b0 || o_busy !== 1'b0) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL blk_ch_en: got %0d busy cycles want 0", seen); end
    i_ch_en = 4'hF; i_sched_en = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (o_tx_req !== 1'b0 || o_tr_en !== 1'b0) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL blk_sched_en: got %0d active cycles want 0", seen); end
    i_req_vld = 4'b0; i_sched_en = 1'b1;
    @(negedge clk);
    i_req_vld = 4'b0010;
    @(negedge clk);
    n_checks++; if (o_tx_req !== 1'b1) begin n_fail++; $display("FAIL blk_pre_reset_req: got %b want 1", o_tx_req); end
    i_reset = 1'b1;
    @(negedge clk);
    n_checks++; if (o_tx_req !== 1'b0 || o_busy !== 1'b0 || {o_req_ack, o_req_err} !== 8'h00) begin
      n_fail++; $display("FAIL blk_mid_reset: got req=%b busy=%b ack/err=%h want 0/0/00", o_tx_req, o_busy, {o_req_ack, o_req_err});
    end
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    i_req_vld = 4'b0101;
    do_frame(1, 4'hF, 1'b0, '0, '0, wt, h, g, d, c, s, a, e, p, b);
    n_checks++; if (g !== rr_pick(4'b0101) || c !== 16'd434 || a !== 4'b0001) begin
      n_fail++; $display("FAIL blk_restart: got ch%0d comp=%0d ack=%b want ch0 434 0001", g, c, a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cfg();
    test_timeout();
    test_random();
    test_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
